mul_dispatcher: RTL and testbench
=================================

MUL_DISPATCHER -- requirements
Module: mul_dispatcher

Interface
REQ-001 Parameter LEN, default 32, operand width in bits; the product is 2*LEN bits.
REQ-002 Parameter FIFO_DEPTH, default 4, operand-queue entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  operand-pair handshake.
REQ-006 in_a, in_b  input  LEN each  multiplicand and multiplier.
REQ-007 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-008 out_product  output  2*LEN  result, valid while out_valid=1.
REQ-009 mul_rst  output  1  active-high reset pulse to the downstream multiplier.
REQ-010 mul_start  output  1  start pulse to the multiplier.
REQ-011 mul_multiplicand, mul_multiplier  output  LEN each  operands held stable from LOAD until the result is captured.
REQ-012 mul_product, mul_finish  input  2*LEN / 1  multiplier result and done flag.
REQ-013 busy  output  1  high when the FSM is not in IDLE or the queue is non-empty.
REQ-014 err_timeout  output  1  sticky; set on a multiplier watchdog expiry.

Function
REQ-015 Input queue: FIFO of FIFO_DEPTH {a,b} pairs.
  - in_ready = !full.
  - A push occurs on in_valid && in_ready.
  - A simultaneous push and pop while full SHALL NOT be accepted, because in_ready is already low.
REQ-016 FSM states: IDLE, CLEAR, LOAD, WAIT, OUT.
REQ-017 IDLE: on non-empty queue, pop the head into the operand registers and go to CLEAR in the same cycle.
REQ-018 CLEAR: mul_rst=1 for exactly 1 cycle, then go to LOAD.
REQ-019 LOAD: mul_start=1 for exactly 1 cycle, then go to WAIT; the watchdog counter is cleared.
REQ-020 WAIT behaviour:
  - mul_finish is ignored during the first 2 WAIT cycles (stale finish after clear).
  - Afterwards, mul_finish=1 captures mul_product into the result register and moves to OUT.
REQ-021 Watchdog: if WAIT lasts 2*LEN+8 cycles without a capture:
  - set err_timeout;
  - load an all-ones product;
  - go to OUT.
REQ-022 OUT: out_valid=1 with out_product stable until out_ready=1, then go to IDLE; a queue entry is never popped in OUT.
REQ-023 Latency: in_valid with an empty queue and idle FSM → out_valid no earlier than 5+N cycles, where N is the multiplier's finish latency.
REQ-024 Results SHALL leave in strict acceptance order; no operand pair is dropped or duplicated.
REQ-025 Pushes continue during CLEAR/LOAD/WAIT/OUT whenever the queue is not full.

Reset
REQ-026 rst_n=0 asynchronously clears the state:
  - FSM → IDLE; queue empty; pointers 0;
  - out_valid=0, out_product=0, mul_start=0, err_timeout=0, busy=0.
REQ-027 During reset mul_rst=1, so the multiplier is held in reset whenever the dispatcher is.
REQ-028 Reset mid-operation discards the queue and any in-flight result; no out_valid follows deassertion.

Configuration
REQ-029 Macro MUL_DISPATCH_SIGNED_EN, when defined, enables two's-complement operands:
  - magnitudes of in_a/in_b are sent to the multiplier;
  - the captured product is negated when the operand signs differ;
  - negation is applied at capture time, adding no cycle.
REQ-030 Without MUL_DISPATCH_SIGNED_EN, operands are unsigned and passed unmodified; no sign logic is present.

Structure
REQ-031 Shared package mul_pkg holds:
  - the FSM state enum typedef;
  - the default LEN;
  - the WAIT blanking constant (2);
  - the watchdog-margin constant (8).
REQ-032 The queue SHALL be a separate sub-module, mul_operand_fifo, parameterised by width and depth.

Verification
REQ-033 Bench scenarios:
  - Single op: a=3, b=5, model finish after 33 cycles → out_product=15 on one out_valid beat.
  - Back-to-back: push 4 pairs (1×1, 2×2, 0xFFFFFFFF×2, 0×7) with out_ready=1 → 1, 4, 0x1_FFFFFFFE, 0 in order.
  - Full/backpressure: push 6 pairs with out_ready=0 → in_ready drops after the queue fills; no loss after release.
  - Stale finish: mul_finish held 1 throughout → no capture in the first 2 WAIT cycles; capture on WAIT cycle 3.
  - Watchdog: mul_finish stuck 0 → err_timeout=1, out_product all-ones after 72 WAIT cycles (LEN=32).
  - Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0, mul_rst=1, queue empty; the next op completes correctly; with MUL_DISPATCH_SIGNED_EN, -3×5 → -15.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier dispatcher.
// This package holds the FSM state type, the default operand width and the WAIT timing constants.
package mul_pkg;

    // Default operand width in bits. The product is twice this width.
    localparam int MUL_LEN_DEFAULT = 32;

    // Number of WAIT cycles during which mul_finish is ignored.
    // A done flag left over from the previous operation can still be high in these cycles.
    localparam int WAIT_BLANK = 2;

    // Extra WAIT cycles, beyond 2*LEN, that the multiplier gets before the watchdog fires.
    localparam int WD_MARGIN = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_WAIT,
        ST_OUT
    } mul_state_t;

    // Number of WAIT cycles allowed without a capture for a given operand width.
    function automatic int wd_limit(input int len);
        return 2 * len + WD_MARGIN;
    endfunction

endpackage

// File: rtl/mul_operand_fifo.sv
// Operand-pair queue for the multiplier dispatcher.
// The head entry can be read directly from the array, so the consumer registers it on the same edge as the pop.
// DEPTH must be a power of two and at least 2.
// Each pointer carries one extra wrap bit, so full and empty can be told apart without a separate count.
module mul_operand_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage array; the contents do not need a reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Advance the read and write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mul_dispatcher.sv
// Multiplier dispatcher.
// - Queues operand pairs and runs each pair through an external multiplier in the order CLEAR, LOAD, WAIT.
// - Presents each result on a valid/ready output.
// - A watchdog replaces a missing result with an all-ones product and sets the sticky err_timeout flag.
// Optional feature: define MUL_DISPATCH_SIGNED_EN for two's-complement operands.
// In that build, operand magnitudes go to the multiplier and the product sign is restored at capture.
module mul_dispatcher
    import mul_pkg::*;
#(
    parameter int LEN        = MUL_LEN_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_a,
    input  logic [LEN-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*LEN-1:0] out_product,
    output logic             mul_rst,
    output logic             mul_start,
    output logic [LEN-1:0]   mul_multiplicand,
    output logic [LEN-1:0]   mul_multiplier,
    input  logic [2*LEN-1:0] mul_product,
    input  logic             mul_finish,
    output logic             busy,
    output logic             err_timeout
);

    localparam int WD_LIMIT = wd_limit(LEN);
    localparam int CW       = $clog2(WD_LIMIT + 1);

    mul_state_t       state_reg;
    logic [CW-1:0]    wait_cnt_reg;
    logic [LEN-1:0]   a_reg;
    logic [LEN-1:0]   b_reg;
    logic             mul_rst_reg;
    logic             mul_start_reg;
    logic             out_valid_reg;
    logic [2*LEN-1:0] out_product_reg;
    logic             err_timeout_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic [2*LEN-1:0] head_data;
    logic [LEN-1:0]   head_a;
    logic [LEN-1:0]   head_b;
    logic             pop_en;
    logic [LEN-1:0]   load_a;
    logic [LEN-1:0]   load_b;
    logic [2*LEN-1:0] captured;

    assign in_ready = !fifo_full;
    assign pop_en   = (state_reg == ST_IDLE) && !fifo_empty;
    assign head_a   = head_data[2*LEN-1:LEN];
    assign head_b   = head_data[LEN-1:0];

    mul_operand_fifo #(
        .WIDTH (2 * LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data ({in_a, in_b}),
        .pop       (pop_en),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef MUL_DISPATCH_SIGNED_EN
    logic neg_reg;

    // Magnitudes go to the multiplier.
    // The most negative value maps onto itself, which is still the correct unsigned magnitude.
    assign load_a   = head_a[LEN-1] ? (~head_a + 1'b1) : head_a;
    assign load_b   = head_b[LEN-1] ? (~head_b + 1'b1) : head_b;
    // The sign is restored in the capture path, so the result is ready in the same cycle.
    assign captured = neg_reg ? (~mul_product + 1'b1) : mul_product;

    // Remember, at pop time, whether the result must be negated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_reg <= 1'b0;
        end else if (pop_en) begin
            neg_reg <= head_a[LEN-1] ^ head_b[LEN-1];
        end
    end
`else
    assign load_a   = head_a;
    assign load_b   = head_b;
    assign captured = mul_product;
`endif

    // Sequencer FSM: pop -> clear multiplier -> start -> wait for finish or watchdog -> hand off the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            wait_cnt_reg    <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            mul_rst_reg     <= 1'b1;
            mul_start_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_product_reg <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            mul_rst_reg   <= 1'b0;
            mul_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        a_reg       <= load_a;
                        b_reg       <= load_b;
                        mul_rst_reg <= 1'b1;
                        state_reg   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    mul_start_reg <= 1'b1;
                    state_reg     <= ST_LOAD;
                end
                ST_LOAD: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_finish && (wait_cnt_reg >= CW'(WAIT_BLANK))) begin
                        out_product_reg <= captured;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= ST_OUT;
                    end else if (wait_cnt_reg == CW'(WD_LIMIT - 1)) begin
                        err_timeout_reg <= 1'b1;
                        out_product_reg <= '1;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= ST_OUT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mul_rst          = mul_rst_reg;
    assign mul_start        = mul_start_reg;
    assign mul_multiplicand = a_reg;
    assign mul_multiplier   = b_reg;
    assign out_valid        = out_valid_reg;
    assign out_product      = out_product_reg;
    assign err_timeout      = err_timeout_reg;
    assign busy             = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_dispatcher.sv
// Bench for mul_dispatcher (LEN=32, FIFO_DEPTH=4).
// - A behavioural multiplier model drives mul_product and mul_finish.
// - The expected product of every accepted operand pair is queued in acceptance order.
// - Results are compared against that queue as they leave the dispatcher.
// Define MUL_DISPATCH_SIGNED_EN here as for the RTL to check the signed build.
module tb_mul_dispatcher;

    localparam int LEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [LEN-1:0]  in_a = '0;
    logic [LEN-1:0]  in_b = '0;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_product;
    logic            mul_rst;
    logic            mul_start;
    logic [LEN-1:0]  mul_multiplicand;
    logic [LEN-1:0]  mul_multiplier;
    logic [63:0]     mul_product;
    logic            mul_finish;
    logic            busy;
    logic            err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ready_mode = 1;     // 0: hold low, 1: hold high, 2: random
    int mm_mode    = 0;     // 0: finish after latency, 1: finish stuck high, 2: finish stuck low
    int mm_lat_cfg = 10;
    bit mm_lat_rand = 1'b0;
    bit wd_expect   = 1'b0;
    logic [63:0] exp_q[$];

    mul_dispatcher #(.LEN(LEN), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .mul_rst(mul_rst), .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_product(mul_product), .mul_finish(mul_finish),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counts one comparison and reports a mismatch.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected product of an operand pair, using plain arithmetic.
    function automatic logic [63:0] ref_prod(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
`ifdef MUL_DISPATCH_SIGNED_EN
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        return 64'(a) * 64'(b);
`endif
    endfunction

    // Downstream multiplier model.
    // The done flag rises a programmable number of cycles after the start pulse.
    // It stays high until the next multiplier reset.
    logic        mm_active;
    logic        mm_fin;
    int          mm_cnt;
    int          mm_lat;
    logic [63:0] mm_prod;

    always @(posedge clk) begin
        if (mul_rst) begin
            mm_active <= 1'b0;
            mm_fin    <= 1'b0;
        end else if (mul_start) begin
            mm_active <= 1'b1;
            mm_cnt    <= 1;
            mm_lat    <= mm_lat_rand ? int'($urandom_range(2, 40)) : mm_lat_cfg;
            mm_prod   <= 64'(mul_multiplicand) * 64'(mul_multiplier);
            mm_fin    <= 1'b0;
        end else if (mm_active) begin
            mm_cnt <= mm_cnt + 1;
            if (mm_cnt == mm_lat - 1) mm_fin <= 1'b1;
        end
    end
    assign mul_product = mm_prod;
    assign mul_finish  = (mm_mode == 1) ? 1'b1 : (mm_mode == 2) ? 1'b0 : mm_fin;

    // Drives out_ready shortly after each rising edge, according to ready_mode.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
        else                 out_ready = (ready_mode == 1);
    end

    // Scoreboard. At the falling edge, a high valid/ready pair means a transfer on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(ref_prod(in_a, in_b));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", out_product, 64'hDEAD);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (wd_expect) e = '1;
                    check("result", out_product, e);
                    $display("[TB] result 0x%0h (expected 0x%0h)", out_product, e);
                end
            end
        end
    end

    // Offers one operand pair until it is accepted or a cycle budget runs out.
    task automatic push_pair(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("push_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits until the dispatcher has drained and every expected result has been seen.
    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy && !out_valid && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        check({tag, "_drained"}, 64'(ok), 64'd1);
    endtask

    // Pushes one pair on an idle dispatcher.
    // Checks the cycle count from the mul_start pulse to the first out_valid.
    task automatic run_timed(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                             input int exp_lat, input string tag);
        int  t_start = -1;
        bit  seen = 1'b0;
        push_pair(a, b);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mul_start && t_start < 0) t_start = cyc;
            if (out_valid) begin seen = 1'b1; break; end
        end
        check({tag, "_out_seen"}, 64'(seen), 64'd1);
        if (seen) check({tag, "_latency"}, 64'(cyc - t_start), 64'(exp_lat));
    endtask

    initial begin
        logic [LEN-1:0] ta[4];
        logic [LEN-1:0] tb_[4];
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_product", out_product, 64'd0);
        check("rst_mul_rst", 64'(mul_rst), 64'd1);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single op, multiplier finishing 33 cycles after start
        mm_lat_cfg = 33;
        run_timed(32'd3, 32'd5, 34, "single");
        wait_idle("single");

        // Back-to-back ops, out_ready held high
        ta[0] = 32'd1; tb_[0] = 32'd1;
        ta[1] = 32'd2; tb_[1] = 32'd2;
        ta[2] = 32'hFFFF_FFFF; tb_[2] = 32'd2;
        ta[3] = 32'd0; tb_[3] = 32'd7;
        mm_lat_cfg = 4;
        for (int i = 0; i < 4; i++) push_pair(ta[i], tb_[i]);
        wait_idle("b2b");

        // Full queue and backpressure
        ready_mode = 0;
        for (int i = 0; i < 5; i++) push_pair(32'(i + 1), 32'(i + 3));
        repeat (20) @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        check("full_hold_valid", 64'(out_valid), 64'd1);
        check("full_hold_product", out_product, ref_prod(32'd1, 32'd3));
        ready_mode = 1;
        push_pair(32'd6, 32'd8);
        wait_idle("full");

        // Stale finish: the done flag is high from the start of WAIT
        mm_mode = 1;
        run_timed(32'd11, 32'd13, 4, "stale");
        wait_idle("stale");
        mm_mode = 0;

        // Watchdog: the done flag never rises
        mm_mode = 2; wd_expect = 1'b1;
        run_timed(32'd9, 32'd9, 73, "wdog");
        check("wdog_err", 64'(err_timeout), 64'd1);
        check("wdog_product", out_product, '1);
        wait_idle("wdog");
        mm_mode = 0; wd_expect = 1'b0;
        mm_lat_cfg = 6;
        push_pair(32'd2, 32'd21);
        wait_idle("post_wdog");
        check("err_sticky", 64'(err_timeout), 64'd1);

        // Random traffic with random latencies and random out_ready
        ready_mode = 2; mm_lat_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [LEN-1:0] ra, rb;
            ra = $urandom(); rb = $urandom();
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0) rb = 32'hFFFF_FFFF;
            push_pair(ra, rb);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle("random");
        ready_mode = 1; mm_lat_rand = 1'b0;

        // Reset in the middle of WAIT
        mm_lat_cfg = 40;
        push_pair(32'd100, 32'd200);
        for (int i = 0; i < 20 && !mul_start; i++) @(negedge clk);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_product", out_product, 64'd0);
        check("midrst_mul_rst", 64'(mul_rst), 64'd1);
        check("midrst_mul_start", 64'(mul_start), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err", 64'(err_timeout), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_valid", 64'(out_valid), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);
        mm_lat_cfg = 5;
`ifdef MUL_DISPATCH_SIGNED_EN
        push_pair(-32'sd3, 32'sd5);
`else
        push_pair(32'd7, 32'd9);
`endif
        wait_idle("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
